// File: rtl/cdp_req_latch_if.sv
// Request-latch bus: request/mask/clear inputs, indexed valid/ready output, status.
// Groups everything except clk/rst so producer and consumer share one bundle.
// master = stimulus/consumer side, slave = the latch itself.
interface cdp_req_latch_if #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
);
  logic [N_REQ-1:0] req_in;
  logic [N_REQ-1:0] mask;
  logic             ovf_clr;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] overflow;

  modport master (
    output req_in, mask, ovf_clr, out_ready,
    input  out_idx, out_valid, pending, overflow
  );

  modport slave (
    input  req_in, mask, ovf_clr, out_ready,
    output out_idx, out_valid, pending, overflow
  );
endinterface

// File: rtl/cdp_req_latch.sv
// Request capture stage: latches request edges/levels into a pending register and
// issues the highest-priority unmasked pending line as a registered index.
// Latency: capture edge k -> out_valid after edge k+1; one index per 2 cycles;
// the issued index is held (never retracted) until out_ready.
module cdp_req_latch #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2,
  parameter bit EDGE  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  cdp_req_latch_if.slave    bus
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] req_q, req_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] overflow_q, overflow_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_valid_q, out_valid_d;

  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] eligible;
  logic [IDX_W-1:0] win_code;
  logic             win_vld;
  logic             accept;

  // Request capture: req_q resets to 0 so a line held high through reset is one edge.
  always_comb begin
    req_d = bus.req_in;
    rise  = EDGE ? (bus.req_in & ~req_q) : bus.req_in;
  end

  // Priority select: ascending scan, so the highest eligible line wins; code = N_REQ-1-line.
  always_comb begin
    eligible = pending_q & ~bus.mask;
    win_vld  = |eligible;
    win_code = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (eligible[i]) begin
        win_code = IDX_W'(N_REQ - 1 - i);
      end
    end
  end

  // Handshake decode: one-hot clear of the line whose index is being accepted.
  always_comb begin
    accept = (state_q == HOLD) && bus.out_ready;
    clr    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (accept && (out_idx_q == IDX_W'(N_REQ - 1 - i))) begin
        clr[i] = 1'b1;
      end
    end
  end

  // Pending/overflow update: a new rise beats the clear of the same line.
  always_comb begin
    pending_d  = (pending_q & ~clr) | rise;
    overflow_d = (bus.ovf_clr ? '0 : overflow_q) | (rise & pending_q & ~clr);
  end

  // FSM next state: IDLE issues when something is eligible, HOLD waits for ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld)       state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: load index on issue, freeze it in HOLD, drop valid on accept.
  always_comb begin
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          out_idx_d   = win_code;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      default: out_valid_d = 1'b0;
    endcase
  end

  // State register: everything clears asynchronously, in-flight requests are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      pending_q   <= '0;
      overflow_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_idx   = out_idx_q;
  assign bus.out_valid = out_valid_q;
  assign bus.pending   = pending_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_cdp_req_latch.sv
// Directed bench for cdp_req_latch: stimulus pushes expected indices into a
// scoreboard queue, a negedge monitor pops and compares on every handshake.
// Status outputs (pending/overflow/valid) are checked directly by the stimulus.
module tb_cdp_req_latch;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [1:0] sb[$];

  cdp_req_latch_if #(.N_REQ(4), .IDX_W(2)) bus ();

  cdp_req_latch #(.N_REQ(4), .IDX_W(2), .EDGE(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must match the oldest expected index.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL handshake: unexpected index %0d with empty scoreboard", bus.out_idx);
      end else begin
        logic [1:0] exp;
        exp = sb.pop_front();
        if (bus.out_idx !== exp) begin
          errors++;
          $display("FAIL handshake: got idx %0d expected %0d", bus.out_idx, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.out_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for out_valid", name);
    end
  endtask

  task automatic accept(input string name, input logic [1:0] exp);
    sb.push_back(exp);
    wait_valid(name);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] r);
    bus.req_in = r;
    tick();
    bus.req_in = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.req_in    = '0;
    bus.mask      = '0;
    bus.ovf_clr   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_idx", 32'(bus.out_idx), 32'd0);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    rst = 1'b0;
    tick();

    // 1: single request on line 0, exact latency
    pulse(4'b0001);
    chk("t1_pending", 32'(bus.pending), 32'h1);
    chk("t1_valid_early", 32'(bus.out_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_idx", 32'(bus.out_idx), 32'd3);
    accept("t1_acc", 2'd3);
    chk("t1_pending_clr", 32'(bus.pending), 32'h0);
    chk("t1_valid_clr", 32'(bus.out_valid), 32'd0);
    tick();

    // 2: two lines, higher line first
    pulse(4'b0101);
    accept("t2_acc_a", 2'd1);
    accept("t2_acc_b", 2'd3);
    chk("t2_pending", 32'(bus.pending), 32'h0);
    tick();

    // 3: masked line stays pending until unmasked
    bus.mask = 4'b1000;
    pulse(4'b1010);
    accept("t3_acc_a", 2'd2);
    tick();
    chk("t3_pending_masked", 32'(bus.pending), 32'h8);
    chk("t3_valid_masked", 32'(bus.out_valid), 32'd0);
    bus.mask = 4'b0000;
    accept("t3_acc_b", 2'd0);
    chk("t3_pending", 32'(bus.pending), 32'h0);
    tick();

    // 4: held index is not replaced by a higher request nor retracted by mask
    pulse(4'b0010);
    wait_valid("t4_wait");
    pulse(4'b1000);
    chk("t4_hold_idx", 32'(bus.out_idx), 32'd2);
    bus.mask = 4'b0010;
    tick();
    chk("t4_mask_idx", 32'(bus.out_idx), 32'd2);
    chk("t4_mask_valid", 32'(bus.out_valid), 32'd1);
    bus.mask = 4'b0000;
    accept("t4_acc_a", 2'd2);
    accept("t4_acc_b", 2'd0);
    chk("t4_pending", 32'(bus.pending), 32'h0);
    tick();

    // 5: overflow on repeat rise, clear, and rise coinciding with accept
    pulse(4'b0100);
    wait_valid("t5_wait");
    chk("t5_no_ovf", 32'(bus.overflow), 32'h0);
    pulse(4'b0100);
    chk("t5_ovf", 32'(bus.overflow), 32'h4);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("t5_ovf_clr", 32'(bus.overflow), 32'h0);
    sb.push_back(2'd1);
    bus.req_in    = 4'b0100;
    bus.out_ready = 1'b1;
    tick();
    bus.req_in    = 4'b0000;
    bus.out_ready = 1'b0;
    chk("t5_set_wins", 32'(bus.pending), 32'h4);
    chk("t5_no_ovf_acc", 32'(bus.overflow), 32'h0);
    accept("t5_acc_b", 2'd1);
    chk("t5_pending", 32'(bus.pending), 32'h0);
    tick();

    // 6: asynchronous reset mid-HOLD, line held high through release
    pulse(4'b0100);
    wait_valid("t6_wait");
    tick();
    pulse(4'b0100);
    chk("t6_ovf_pre", 32'(bus.overflow), 32'h4);
    #2;
    rst        = 1'b1;
    bus.req_in = 4'b1000;
    #1;
    chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_pending", 32'(bus.pending), 32'h0);
    chk("t6_rst_overflow", 32'(bus.overflow), 32'h0);
    chk("t6_rst_idx", 32'(bus.out_idx), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    accept("t6_acc", 2'd0);
    repeat (3) tick();
    chk("t6_one_capture_p", 32'(bus.pending), 32'h0);
    chk("t6_one_capture_v", 32'(bus.out_valid), 32'd0);
    bus.req_in = 4'b0000;
    repeat (2) tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
